// File: rtl/sd_slv_rseq.sv
// sd_slv_rseq: read-block sequencer owning DAT-line timing for SD slave reads.
// Optional access delay enabled by defining SD_SLV_RSEQ_NAC_EN.
`default_nettype none

module sd_slv_rseq #(
  parameter int AW      = 10,
  parameter int BLK_NIB = 1024,
  parameter int CRC_NIB = 16,
  parameter int NAC     = 8,
  parameter int NGAP    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          multi,
  input  logic [AW-1:0] start_addr,
  input  logic          stop_req,
  output logic          read,
  output logic          cen_rom,
  output logic          cen,
  output logic          stop_en,
  output logic          ei,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic [15:0]   blk_cnt
);

  localparam int CW = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_PAD   = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

`ifdef SD_SLV_RSEQ_NAC_EN
  localparam logic [CW-1:0] WAIT_LAST = CW'(NAC);
`else
  localparam logic [CW-1:0] WAIT_LAST = CW'(0 * NAC);
`endif
  localparam logic [CW-1:0] DATA_LAST = CW'(BLK_NIB - 1);
  localparam logic [CW-1:0] CRC_LAST  = CW'(CRC_NIB - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(NGAP - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          multi_q, multi_d;
  logic          stop_lat_q, stop_lat_d;
  logic          end_q, end_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;
  logic          read_q, cen_rom_q, cen_q, stop_en_q, ei_q, busy_q, done_q;
  logic          read_d, cen_rom_d, cen_d, stop_en_d, ei_d, busy_d, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      multi_q    <= 1'b0;
      stop_lat_q <= 1'b0;
      end_q      <= 1'b0;
      blk_cnt_q  <= '0;
      read_q     <= 1'b0;
      cen_rom_q  <= 1'b0;
      cen_q      <= 1'b0;
      stop_en_q  <= 1'b0;
      ei_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      multi_q    <= multi_d;
      stop_lat_q <= stop_lat_d;
      end_q      <= end_d;
      blk_cnt_q  <= blk_cnt_d;
      read_q     <= read_d;
      cen_rom_q  <= cen_rom_d;
      cen_q      <= cen_d;
      stop_en_q  <= stop_en_d;
      ei_q       <= ei_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    multi_d    = multi_q;
    stop_lat_d = stop_lat_q;
    end_d      = end_q;
    blk_cnt_d  = blk_cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_WAIT;
        addr_d    = start_addr;
        multi_d   = multi;
        blk_cnt_d = '0;
      end
      S_WAIT:  if (cnt_q == WAIT_LAST) state_d = S_START;
      S_START: state_d = S_DATA;
      S_DATA: begin
        addr_d = addr_q + 1'b1;
        if (cnt_q == DATA_LAST) state_d = S_CRC;
      end
      S_CRC: if (cnt_q == CRC_LAST) state_d = S_PAD;
      S_PAD: begin
        // Outputs are registered, so the end-of-transfer decision is made on entry to STOP.
        state_d   = S_STOP;
        end_d     = !multi_q || stop_lat_q || stop_req;
        blk_cnt_d = blk_cnt_q + 16'd1;
      end
      S_STOP:  state_d = end_q ? S_IDLE : S_GAP;
      default: if (cnt_q == GAP_LAST) state_d = S_START;
    endcase
    if (state_q != S_IDLE && multi_q && stop_req) stop_lat_d = 1'b1;
    if (state_d == S_IDLE) stop_lat_d = 1'b0;
    cnt_d = (state_d == state_q && state_d != S_IDLE) ? cnt_q + 1'b1 : '0;
  end

  always_comb begin
    read_d    = (state_d == S_START);
    cen_rom_d = (state_d == S_DATA);
    cen_d     = (state_d == S_CRC);
    stop_en_d = (state_d == S_STOP);
    ei_d      = (state_d == S_DATA) || (state_d == S_CRC) ||
                (state_d == S_PAD)  || (state_d == S_STOP);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_STOP) && end_d;
  end

  assign read    = read_q;
  assign cen_rom = cen_rom_q;
  assign cen     = cen_q;
  assign stop_en = stop_en_q;
  assign ei      = ei_q;
  assign addr    = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign blk_cnt = blk_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_slv_rseq.sv
// tb_sd_slv_rseq: directed scoreboard bench for the SD read-block sequencer.
`default_nettype none

module tb_sd_slv_rseq;
  localparam int AW   = 10;
  localparam int BLK  = 1024;
  localparam int CRC  = 16;
  localparam int NGAP = 2;
`ifdef SD_SLV_RSEQ_NAC_EN
  localparam int LAT = 8 + 2;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          multi = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          stop_req = 1'b0;
  logic          read, cen_rom, cen, stop_en, ei, busy, done;
  logic [AW-1:0] addr;
  logic [15:0]   blk_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] sb[$];

  sd_slv_rseq #(.AW(AW), .BLK_NIB(BLK), .CRC_NIB(CRC), .NAC(8), .NGAP(NGAP)) dut (
    .clk(clk), .rst(rst), .start(start), .multi(multi), .start_addr(start_addr),
    .stop_req(stop_req), .read(read), .cen_rom(cen_rom), .cen(cen), .stop_en(stop_en),
    .ei(ei), .addr(addr), .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [4:0] strb = {read, cen_rom, cen, stop_en, ei};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic do_start(input bit m, input logic [AW-1:0] a, input bit with_stop);
    int s;
    int n;
    @(posedge clk); #1;
    start = 1'b1; multi = m; start_addr = a; stop_req = with_stop; s = cyc;
    @(posedge clk); #1;
    start = 1'b0; stop_req = 1'b0;
    exp_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!read && n < LAT + 10);
    chk("read_latency", cyc - s, LAT);
  endtask

  // Leaves the bench at the negedge of the next block's read cycle when not last.
  task automatic check_block(input int nblk, input bit last, input int stop_at, input int start_at);
    logic [AW-1:0] a;
    for (int i = 0; i < BLK; i++) begin sb.push_back(exp_addr); exp_addr++; end
    for (int k = 1; k <= BLK + CRC + 2; k++) begin
      stop_req = (k == stop_at);
      start    = (k == start_at);
      if (k == start_at) start_addr = 10'h155;
      @(negedge clk);
      if (k <= BLK) begin
        chk("data_strobes", strb, 5'b01001);
        a = sb.pop_front();
        chk("data_addr", addr, a);
      end else if (k <= BLK + CRC) chk("crc_strobes", strb, 5'b00101);
      else if (k == BLK + CRC + 1) chk("pad_strobes", strb, 5'b00001);
      else begin
        chk("stop_strobes", strb, 5'b00011);
        chk("stop_done", done, last);
        chk("stop_blk_cnt", blk_cnt, nblk);
      end
    end
    start = 1'b0; stop_req = 1'b0;
    if (last) begin
      @(negedge clk);
      chk("after_done", {strb, busy, done}, 7'b0);
    end else begin
      for (int g = 1; g <= NGAP; g++) begin
        stop_req = (BLK + CRC + 2 + g == stop_at);
        @(negedge clk);
        chk("gap", {strb, busy, done}, 7'b0000010);
      end
      stop_req = 1'b0;
      @(negedge clk);
      chk("block_period_read", read, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_strobes", {strb, busy, done}, 7'b0);
    chk("reset_addr", addr, 0);
    chk("reset_blk_cnt", blk_cnt, 0);

    // stop_req while idle must not start anything
    @(posedge clk); #1 stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0;
    @(negedge clk);
    chk("idle_stop_busy", busy, 1'b0);

    // single block with address wrap, ignored start and ignored stop mid-block
    do_start(1'b0, 10'h3F0, 1'b0);
    check_block(1, 1'b1, 300, 200);

    // multi-block; stop coincident with start is ignored, stop in block 3 DATA honoured
    do_start(1'b1, 10'h100, 1'b1);
    check_block(1, 1'b0, -1, -1);
    check_block(2, 1'b0, -1, -1);
    check_block(3, 1'b1, 50, -1);

    // stop arriving in GAP ends the transfer after the following block
    do_start(1'b1, 10'h200, 1'b0);
    check_block(1, 1'b0, BLK + CRC + 4, -1);
    check_block(2, 1'b1, -1, -1);

    // reset 100 cycles into DATA
    do_start(1'b1, 10'h010, 1'b0);
    repeat (100) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_strobes", {strb, busy, done}, 7'b0);
    chk("midreset_addr", addr, 0);
    chk("midreset_blk_cnt", blk_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midreset_quiet", {stop_en, busy}, 2'b00);
    end

    do_start(1'b0, 10'h000, 1'b0);
    check_block(1, 1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
